// File: rtl/br_elastic.sv
// In-order elastic buffer of SLOTS entries on one valid/ready channel, with optional bypass while empty.
// Latency: 1 cycle when TRANSPARENT=0; 0 cycles when TRANSPARENT=1 and the buffer is empty.
// Backpressure: ins_ready drops only when full and outs_ready is low; when full, input is taken in the cycle the head drains.
module br_elastic #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLOTS       = 2,
    parameter bit TRANSPARENT = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic [DATA_WIDTH-1:0]        outs,
    output logic                         outs_valid,
    input  logic                         outs_ready,
    output logic [$clog2(SLOTS+1)-1:0]   occupancy
);
    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(SLOTS + 1);

    logic [DATA_WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    logic empty;
    logic full;
    logic bypass;
    logic in_fire;
    logic out_fire;
    logic wr_en;
    logic rd_en;

    // Explicit compare-and-clear so non-power-of-two depths wrap at SLOTS-1.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(SLOTS - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(SLOTS));
        bypass     = TRANSPARENT && empty;
        ins_ready  = !rst && (!full || outs_ready);
        outs_valid = !rst && (bypass ? ins_valid : !empty);
        outs       = bypass ? ins : mem[head];
        occupancy  = rst ? '0 : count;
        in_fire    = ins_valid && ins_ready;
        out_fire   = outs_valid && outs_ready;
        // A bypassed token that is consumed immediately never touches storage.
        wr_en      = in_fire && !(bypass && outs_ready);
        rd_en      = out_fire && !bypass;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= ptr_next(tail);
            if (rd_en) head <= ptr_next(head);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[tail] <= ins;
    end
endmodule

// File: tb/tb_br_elastic.sv
// Bench for br_elastic: five instances cover opaque depths 1-4 and a transparent SLOTS=2 case.
module tb_br_elastic;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sl_of(input int i);
        case (i)
            0: return 2;
            1: return 3;
            2: return 2;
            3: return 1;
            default: return 4;
        endcase
    endfunction

    logic        rst        [5];
    logic [31:0] ins        [5];
    logic        ins_valid  [5];
    logic        ins_ready  [5];
    logic [31:0] outs       [5];
    logic        outs_valid [5];
    logic        outs_ready [5];
    logic [2:0]  occ        [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int S  = sl_of(g);
        localparam int OW = $clog2(S + 1);
        logic [OW-1:0] occ_l;
        br_elastic #(.DATA_WIDTH(32), .SLOTS(S), .TRANSPARENT(g == 2)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .ins        (ins[g]),
            .ins_valid  (ins_valid[g]),
            .ins_ready  (ins_ready[g]),
            .outs       (outs[g]),
            .outs_valid (outs_valid[g]),
            .outs_ready (outs_ready[g]),
            .occupancy  (occ_l)
        );
        assign occ[g] = 3'(occ_l);
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q [$];

    typedef struct {
        int          id;
        bit          r;
        bit          iv;
        logic [31:0] d;
        bit          ordy;
        bit          e_ir;
        bit          e_ov;
        logic [31:0] e_outs;
        int          e_occ;
    } vec_t;
    vec_t tbl [$];

    function automatic void add(input int id, input bit r, input bit iv, input logic [31:0] d, input bit ordy,
                                input bit e_ir, input bit e_ov, input logic [31:0] e_outs, input int e_occ);
        vec_t v;
        v.id = id; v.r = r; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_outs = e_outs; v.e_occ = e_occ;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input bit r, input bit iv, input logic [31:0] d, input bit ordy);
        rst[id]        = r;
        ins_valid[id]  = iv;
        ins[id]        = d;
        outs_ready[id] = ordy;
    endtask

    // Sample on the falling edge; scoreboard push happens before pop so a same-cycle bypass matches.
    task automatic samp(input int id, output bit inf, output bit outf);
        @(negedge clk);
        inf  = ins_valid[id] && ins_ready[id];
        outf = outs_valid[id] && outs_ready[id];
        if (inf) q.push_back(ins[id]);
        if (outf) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_token: got %0h expected none", outs[id]);
            end else begin
                chk("sb_order", outs[id], q.pop_front());
            end
        end
        checks++;
        if (int'(occ[id]) > sl_of(id)) begin
            errors++;
            $display("FAIL occ_bound: got %0d expected <= %0d", occ[id], sl_of(id));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit inf, outf;
        int sent, rcvd;
        for (int i = 0; i < 5; i++) drive(i, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive(i, 1'b0, 1'b0, 32'h0, 1'b0);

        // id rst iv data ordy | ir ov outs occ
        for (int k = 0; k < 3; k++) add(0, 1, 1, 32'hA5, 1, 0, 0, 32'h0, 0);
        add(0, 0, 1, 32'hA5, 1, 1, 0, 32'h0,  0);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'hA5, 1);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
        add(1, 0, 1, 32'h1,  0, 1, 0, 32'h0,  0);
        add(1, 0, 1, 32'h2,  0, 1, 1, 32'h1,  1);
        add(1, 0, 1, 32'h3,  0, 1, 1, 32'h1,  2);
        add(1, 0, 1, 32'h4,  0, 0, 1, 32'h1,  3);
        add(1, 0, 1, 32'h4,  0, 0, 1, 32'h1,  3);
        add(1, 0, 1, 32'h4,  1, 1, 1, 32'h1,  3);
        add(1, 0, 0, 32'h0,  1, 1, 1, 32'h2,  3);
        add(1, 0, 0, 32'h0,  1, 1, 1, 32'h3,  2);
        add(1, 0, 0, 32'h0,  1, 1, 1, 32'h4,  1);
        add(1, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);
        add(2, 0, 1, 32'h55, 1, 1, 1, 32'h55, 0);
        add(2, 0, 1, 32'h66, 0, 1, 1, 32'h66, 0);
        add(2, 0, 1, 32'h77, 1, 1, 1, 32'h66, 1);
        add(2, 0, 0, 32'h0,  1, 1, 1, 32'h77, 1);
        add(2, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.id, v.r, v.iv, v.d, v.ordy);
            samp(v.id, inf, outf);
            chk($sformatf("row%0d_ins_ready", i), 32'(ins_ready[v.id]), 32'(v.e_ir));
            chk($sformatf("row%0d_outs_valid", i), 32'(outs_valid[v.id]), 32'(v.e_ov));
            if (v.e_ov) chk($sformatf("row%0d_outs", i), outs[v.id], v.e_outs);
            chk($sformatf("row%0d_occupancy", i), 32'(occ[v.id]), v.e_occ);
            adv();
        end
        chk("table_drain", q.size(), 0);

        // Random handshakes across many wraps of a depth-3 ring.
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
            drive(1, 1'b0, (sent < 1000) && ($urandom_range(3) != 0), 32'(sent), $urandom_range(2) != 0);
            samp(1, inf, outf);
            if (inf) sent++;
            if (outf) rcvd++;
            adv();
        end
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_sent", sent, 1000);
        chk("wrap_rcvd", rcvd, 1000);
        chk("wrap_drain", q.size(), 0);

        // SLOTS=1 at full rate: 20 tokens in 21 cycles.
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 21; c++) begin
            drive(3, 1'b0, sent < 20, 32'h100 + 32'(sent), 1'b1);
            samp(3, inf, outf);
            if (c == 0) chk("fr_first_latency", 32'(outs_valid[3]), 0);
            if (ins_valid[3]) chk($sformatf("fr_ins_ready_c%0d", c), 32'(ins_ready[3]), 1);
            if (inf) sent++;
            if (outf) rcvd++;
            adv();
        end
        drive(3, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("fr_sent", sent, 20);
        chk("fr_rcvd", rcvd, 20);

        // Reset with three tokens stored; none may reappear.
        for (int k = 0; k < 3; k++) begin
            drive(4, 1'b0, 1'b1, 32'hD1 + 32'(k), 1'b0);
            samp(4, inf, outf);
            adv();
        end
        drive(4, 1'b0, 1'b0, 32'h0, 1'b0);
        samp(4, inf, outf);
        chk("mid_occ_before", 32'(occ[4]), 3);
        adv();
        drive(4, 1'b1, 1'b1, 32'hEE, 1'b1);
        samp(4, inf, outf);
        chk("mid_rst_ins_ready", 32'(ins_ready[4]), 0);
        chk("mid_rst_outs_valid", 32'(outs_valid[4]), 0);
        chk("mid_rst_occ", 32'(occ[4]), 0);
        adv();
        q.delete();
        drive(4, 1'b0, 1'b0, 32'h0, 1'b1);
        samp(4, inf, outf);
        chk("mid_after_occ", 32'(occ[4]), 0);
        chk("mid_after_outs_valid", 32'(outs_valid[4]), 0);
        adv();
        drive(4, 1'b0, 1'b1, 32'hE1, 1'b1);
        samp(4, inf, outf);
        chk("mid_accept", 32'(ins_ready[4]), 1);
        adv();
        drive(4, 1'b0, 1'b0, 32'h0, 1'b1);
        samp(4, inf, outf);
        chk("mid_new_valid", 32'(outs_valid[4]), 1);
        chk("mid_new_data", outs[4], 32'hE1);
        adv();
        chk("mid_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
